// File: rtl/blur_pkg.sv
// rtl/blur_pkg.sv - shared states, default geometry and counter widths for the blur frame controller
package blur_pkg;

  localparam int IMG_W_DEF      = 640;
  localparam int IMG_H_DEF      = 480;
  localparam int FILL_SLACK_DEF = 64;

  localparam int CNT_W  = 19;
  localparam int FILL_W = 12;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } blur_state_e;

  // Pixel count of a frame, sized to the in/out counters.
  function automatic logic [CNT_W-1:0] frame_pix(input int w, input int h);
    return CNT_W'(w * h);
  endfunction

endpackage

// File: rtl/blur_xy_counter.sv
// rtl/blur_xy_counter.sv - raster x/y generator: x wraps at IMG_W-1 and carries into y
module blur_xy_counter
  import blur_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           inc,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/blur_frame_ctrl.sv
// rtl/blur_frame_ctrl.sv - frame sequencer for blur_5x5: fill, run, zero-padded drain, coordinate output
// Defining BLUR_CYCLE_CNT_EN adds the cycle_cnt port (busy cycles of the last frame).
module blur_frame_ctrl
  import blur_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int FILL_LAT   = 2 * IMG_W + 2,
  parameter int FILL_SLACK = FILL_SLACK_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_r,
  input  logic [7:0]     in_g,
  input  logic [7:0]     in_b,
  output logic           blur_en,
  output logic [7:0]     blur_r,
  output logic [7:0]     blur_g,
  output logic [7:0]     blur_b,
  input  logic           blur_rd_flag,
  input  logic [7:0]     blur_r_out,
  input  logic [7:0]     blur_g_out,
  input  logic [7:0]     blur_b_out,
  output logic           out_valid,
  output logic [7:0]     out_r,
  output logic [7:0]     out_g,
  output logic [7:0]     out_b,
  output logic [X_W-1:0] out_x,
  output logic [Y_W-1:0] out_y,
  output logic           busy,
  output logic           done,
  output logic           error
`ifdef BLUR_CYCLE_CNT_EN
  ,
  output logic [31:0]    cycle_cnt
`endif
);

  localparam logic [CNT_W-1:0]  FRAME      = frame_pix(IMG_W, IMG_H);
  localparam logic [CNT_W-1:0]  FRAME_M1   = FRAME - 1'b1;
  localparam logic [FILL_W-1:0] FILL_LIMIT = FILL_W'(FILL_LAT + FILL_SLACK);
  localparam logic [FILL_W-1:0] FILL_MAX   = '1;

  blur_state_e state, state_nxt;

  logic [CNT_W-1:0]  in_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic [FILL_W-1:0] fill_cnt;
  logic [X_W-1:0]    next_x;
  logic [Y_W-1:0]    next_y;

  logic start_ok;
  logic in_phase;
  logic fill_timeout;
  logic accept;
  logic capture;
  logic last_out;
  logic in_exhausted;

  always_comb begin
    start_ok     = 1'b0;
    in_phase     = 1'b0;
    fill_timeout = 1'b0;
    in_ready     = 1'b0;
    accept       = 1'b0;
    blur_en      = 1'b0;
    blur_r       = '0;
    blur_g       = '0;
    blur_b       = '0;
    capture      = 1'b0;
    last_out     = 1'b0;
    in_exhausted = 1'b0;
    busy         = (state != ST_IDLE);
    done         = (state == ST_DONE);
    state_nxt    = state;

    start_ok     = (state == ST_IDLE) && start;
    in_phase     = (state == ST_FILL) || (state == ST_RUN);
    fill_timeout = (state == ST_FILL) && (fill_cnt > FILL_LIMIT);
    // The timeout cycle stops accepting so the advance count at error is exact.
    in_ready     = in_phase && (in_cnt < FRAME) && !fill_timeout;
    accept       = in_ready && in_valid;
    blur_en      = accept || (state == ST_DRAIN);
    if (in_phase) begin
      blur_r = in_r;
      blur_g = in_g;
      blur_b = in_b;
    end
    capture      = blur_en && blur_rd_flag && (out_cnt < FRAME);
    last_out     = capture && (out_cnt == FRAME_M1);
    in_exhausted = (in_cnt == FRAME) || (accept && (in_cnt == FRAME_M1));

    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_FILL;
      ST_FILL: begin
        if (fill_timeout || last_out) state_nxt = ST_DONE;
        else if (capture)             state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (last_out)          state_nxt = ST_DONE;
        else if (in_exhausted) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (last_out) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      fill_cnt  <= '0;
      error     <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= capture;
      if (start_ok) begin
        in_cnt   <= '0;
        out_cnt  <= '0;
        fill_cnt <= '0;
        error    <= 1'b0;
      end else begin
        if (accept) in_cnt <= in_cnt + 1'b1;
        if (capture) begin
          out_cnt <= out_cnt + 1'b1;
          out_r   <= blur_r_out;
          out_g   <= blur_g_out;
          out_b   <= blur_b_out;
          out_x   <= next_x;
          out_y   <= next_y;
        end
        if ((state == ST_FILL) && blur_en && (fill_cnt != FILL_MAX)) fill_cnt <= fill_cnt + 1'b1;
        if (fill_timeout) error <= 1'b1;
      end
    end
  end

  // Holds the coordinate that the next captured pixel will carry.
  blur_xy_counter #(
    .IMG_W (IMG_W)
  ) u_xy (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_ok),
    .inc   (capture),
    .x     (next_x),
    .y     (next_y)
  );

`ifdef BLUR_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)        cycle_cnt <= '0;
    else if (start_ok) cycle_cnt <= '0;
    else if (busy)     cycle_cnt <= cycle_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_blur_frame_ctrl.sv
// tb/tb_blur_frame_ctrl.sv - randomized scoreboard bench for blur_frame_ctrl with a delay-line blur stand-in
module tb_blur_frame_ctrl;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int LAT   = 2 * W + 2;
  localparam int SLACK = 4;
  localparam int FRAME = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic       blur_en;
  logic [7:0] blur_r, blur_g, blur_b;
  logic       blur_rd_flag = 1'b0;
  logic [7:0] blur_r_out = '0, blur_g_out = '0, blur_b_out = '0;
  logic       out_valid;
  logic [7:0] out_r, out_g, out_b;
  logic [9:0] out_x;
  logic [8:0] out_y;
  logic       busy, done, error;
`ifdef BLUR_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  always #5 clk = ~clk;

  blur_frame_ctrl #(
    .IMG_W(W), .IMG_H(H), .FILL_LAT(LAT), .FILL_SLACK(SLACK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .blur_en(blur_en), .blur_r(blur_r), .blur_g(blur_g), .blur_b(blur_b),
    .blur_rd_flag(blur_rd_flag),
    .blur_r_out(blur_r_out), .blur_g_out(blur_g_out), .blur_b_out(blur_b_out),
    .out_valid(out_valid), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_x(out_x), .out_y(out_y),
    .busy(busy), .done(done), .error(error)
`ifdef BLUR_CYCLE_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  int  n_vec = 0;
  int  n_err = 0;
  int  n_out = 0;
  int  n_drain = 0;
  int  adv_cnt = 0;
  bit  flag_en = 1'b1;
  logic [42:0] exp_q[$];
  logic [23:0] dl[$];

  function automatic logic [23:0] blur_fn(input logic [23:0] p);
    return {p[23:16] ^ 8'hA5, p[15:8] + 8'd3, ~p[7:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Blur stand-in: output is the input seen LAT advances earlier; flags once the line is full.
  always @(negedge clk) begin
    logic [23:0] px;
    if (!rst_n || (start && !busy)) begin
      dl.delete();
      adv_cnt = 0;
    end
    blur_rd_flag = flag_en && (dl.size() == LAT);
    px = (dl.size() > 0) ? blur_fn(dl[0]) : 24'h0;
    {blur_r_out, blur_g_out, blur_b_out} = px;
    if (rst_n && blur_en) begin
      dl.push_back({blur_r, blur_g, blur_b});
      adv_cnt++;
      if (dl.size() > LAT) void'(dl.pop_front());
    end
  end

  // Monitor: pops the scoreboard on every output and checks the blur-side drive.
  always @(negedge clk) begin
    logic [42:0] e;
    if (out_valid) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("out_unexpected", {out_r, out_g, out_b, out_x, out_y}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("out_pix", {out_r, out_g, out_b, out_x, out_y}, e);
      end
    end
    if (busy && in_ready) begin
      chk("blur_en_mirror", blur_en, in_valid);
      if (in_valid) chk("blur_pass", {blur_r, blur_g, blur_b}, {in_r, in_g, in_b});
    end
    if (blur_en && !in_ready) begin
      n_drain++;
      chk("drain_zero", {blur_r, blur_g, blur_b}, 24'h0);
    end
  end

  // mode: 0 continuous, 1 toggling, 2 random valid with stray start pulses
  task automatic run_frame(input int mode, input bit flag_ok, input int rst_at);
    int acc, out0, busy_cyc;
    bit seen_done;
    acc = 0; busy_cyc = 0; seen_done = 1'b0;
    flag_en = flag_ok;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("error_cleared", error, 1'b0);
    chk("busy_in_fill", busy, 1'b1);
    out0 = n_out;
    n_drain = 0;
    for (int cyc = 0; cyc < 2000 && !seen_done; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ((cyc % 2) == 0);
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      start = (mode == 2) && ($urandom_range(0, 5) == 0);
      {in_r, in_g, in_b} = 24'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back({blur_fn({in_r, in_g, in_b}), 10'(acc % W), 9'(acc / W)});
        acc++;
      end
      busy_cyc++;
      if (done) seen_done = 1'b1;
      if (rst_at >= 0 && (n_out - out0) >= rst_at) begin
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_xy", {out_x, out_y}, 19'h0);
        exp_q.delete();
        return;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    if (!seen_done) chk("done_timeout", 1'b0, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("done_one_cycle", done, 1'b0);
    chk("error_state", error, !flag_ok);
    if (!flag_ok) begin
      chk("timeout_advances", adv_cnt, LAT + SLACK + 1);
      exp_q.delete();
    end else begin
      chk("accepted", acc, FRAME);
      chk("outputs", n_out - out0, FRAME);
      chk("queue_empty", exp_q.size(), 0);
      chk("drain_cycles", n_drain, LAT);
    end
`ifdef BLUR_CYCLE_CNT_EN
    chk("cycle_cnt", cycle_cnt, busy_cyc);
    repeat (3) @(posedge clk);
    #1;
    chk("cycle_cnt_hold", cycle_cnt, busy_cyc);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d outputs expected bounded run", n_out);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready0", in_ready, 1'b0);
    chk("rst_blur_en0", blur_en, 1'b0);
    chk("rst_out_valid0", out_valid, 1'b0);
    chk("rst_busy0", busy, 1'b0);
    chk("rst_done0", done, 1'b0);
    chk("rst_error0", error, 1'b0);
    chk("rst_out0", {out_r, out_g, out_b, out_x, out_y}, 43'h0);
`ifdef BLUR_CYCLE_CNT_EN
    chk("rst_cycle_cnt0", cycle_cnt, 32'h0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame(0, 1'b1, -1);
    run_frame(1, 1'b1, -1);
    run_frame(2, 1'b1, -1);
    run_frame(0, 1'b0, -1);
    run_frame(2, 1'b1, -1);
    run_frame(0, 1'b1, 10);
    run_frame(1, 1'b1, -1);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
